// File: rtl/nvme_queue_engine.sv
`default_nettype none
// ============================================================================
// Module      : nvme_queue_engine
// Description : NVMe I/O queue pair engine. Builds READ/WRITE SQEs into the
//               SQ ring, rings SQ/CQ doorbells over AXI-Lite and consumes CQEs
//               with phase-tag tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module nvme_queue_engine #(
    parameter int          QDEPTH     = 16,
    parameter int          QID        = 1,
    parameter int          NSID       = 1,
    parameter int          DSTRD      = 0,
    parameter logic [31:0] DB_BASE    = 32'h1000,
    parameter logic [63:0] SQ_BASE    = 64'h20000,
    parameter logic [63:0] BUF_BASE   = 64'h0,
    parameter int          SLOT_BYTES = 4096,
    parameter int          LBA_BYTES  = 512,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [63:0]                 cmd_slba,
    input  logic [7:0]                  cmd_nlb,
    output logic [$clog2(QDEPTH)-1:0]   cmd_cid,
    output logic                        sqe_valid,
    input  logic                        sqe_ready,
    output logic [ADDR_WIDTH-1:0]       sqe_addr,
    output logic [511:0]                sqe_data,
    output logic [31:0]                 db_awaddr,
    output logic                        db_awvalid,
    input  logic                        db_awready,
    output logic [31:0]                 db_wdata,
    output logic                        db_wvalid,
    input  logic                        db_wready,
    input  logic                        db_bvalid,
    output logic                        db_bready,
    input  logic [1:0]                  db_bresp,
    input  logic                        cqe_valid,
    output logic                        cqe_ready,
    input  logic [127:0]                cqe_data,
    output logic                        cpl_valid,
    input  logic                        cpl_ready,
    output logic [15:0]                 cpl_cid,
    output logic [14:0]                 cpl_status,
    output logic                        err_phase,
    output logic                        err_bresp
);

    localparam int                    c_qw      = $clog2(QDEPTH);
    localparam logic [c_qw-1:0]       c_one     = c_qw'(1);
    localparam logic [c_qw-1:0]       c_last    = c_qw'(QDEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_sq_base = SQ_BASE[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] c_buf_base = BUF_BASE[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] c_slot    = ADDR_WIDTH'(SLOT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] c_page    = ADDR_WIDTH'(4096);
    localparam logic [31:0]           c_sq_db   = DB_BASE + 32'((2 * QID) * (4 << DSTRD));
    localparam logic [31:0]           c_cq_db   = DB_BASE + 32'((2 * QID + 1) * (4 << DSTRD));

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_addr = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    logic [c_qw-1:0]       r_sq_tail, r_sq_head, r_cq_head;
    logic                  r_phase;
    logic                  r_sqe_valid;
    logic [ADDR_WIDTH-1:0] r_sqe_addr;
    logic [511:0]          r_sqe_data;
    logic                  r_sq_pend, r_cq_pend;
    logic [1:0]            r_state, w_state_nxt;
    logic                  r_awvalid, r_wvalid;
    logic [31:0]           r_awaddr, r_wdata;
    logic                  r_err_bresp, r_err_phase;
    logic                  r_cpl_valid;
    logic [15:0]           r_cpl_cid;
    logic [14:0]           r_cpl_status;

    logic                  w_full, w_cmd_acc, w_sqe_hs;
    logic                  w_cqe_rdy, w_cqe_acc, w_ph_ok;
    logic                  w_db_start;
    logic                  w_span;
    logic [ADDR_WIDTH-1:0] w_prp1, w_prp2;
    logic [511:0]          w_sqe;

    assign w_full    = (r_sq_tail + c_one) == r_sq_head;
    assign cmd_ready = ~w_full & ~r_sqe_valid;
    assign cmd_cid   = r_sq_tail;
    assign w_cmd_acc = cmd_valid & cmd_ready;
    assign w_sqe_hs  = r_sqe_valid & sqe_ready;

    // PRP1 sits at the slot start, so a second page is needed once the transfer exceeds 4 KiB
    assign w_span = ((32'(cmd_nlb) + 32'd1) * 32'(LBA_BYTES)) > 32'd4096;
    assign w_prp1 = c_buf_base + ADDR_WIDTH'(r_sq_tail) * c_slot;
    assign w_prp2 = w_span ? (w_prp1 + c_page) : '0;

    always_comb begin
        w_sqe            = '0;
        w_sqe[31:0]      = {16'(r_sq_tail), 2'b00, 4'b0000, 2'b00, (cmd_write ? 8'h01 : 8'h02)};
        w_sqe[63:32]     = 32'(NSID);
        w_sqe[255:192]   = 64'(w_prp1);
        w_sqe[319:256]   = 64'(w_prp2);
        w_sqe[383:320]   = cmd_slba;
        w_sqe[415:384]   = {24'b0, cmd_nlb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sqe_valid <= 1'b0;
            r_sq_tail   <= '0;
        end else if (w_cmd_acc) begin
            r_sqe_valid <= 1'b1;
        end else if (w_sqe_hs) begin
            r_sqe_valid <= 1'b0;
            r_sq_tail   <= r_sq_tail + c_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_cmd_acc) begin
            r_sqe_data <= w_sqe;
            r_sqe_addr <= c_sq_base + (ADDR_WIDTH'(r_sq_tail) << 6);
        end
    end

    assign sqe_valid = r_sqe_valid;
    assign sqe_addr  = r_sqe_addr;
    assign sqe_data  = r_sqe_data;

    // CQE intake; phase lives in DW3[16], new SQ head in DW2[15:0]
    assign w_cqe_rdy = ~r_cpl_valid | cpl_ready;
    assign w_cqe_acc = cqe_valid & w_cqe_rdy;
    assign w_ph_ok   = cqe_data[112] == r_phase;
    assign cqe_ready = w_cqe_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sq_head   <= '0;
            r_cq_head   <= '0;
            r_phase     <= 1'b1;
            r_cpl_valid <= 1'b0;
            r_cpl_cid   <= '0;
            r_cpl_status <= '0;
            r_err_phase <= 1'b0;
        end else begin
            r_err_phase <= w_cqe_acc & ~w_ph_ok;
            if (w_cqe_acc && w_ph_ok) begin
                r_sq_head    <= cqe_data[64 +: c_qw];
                r_cq_head    <= r_cq_head + c_one;
                if (r_cq_head == c_last) begin
                    r_phase <= ~r_phase;
                end
                r_cpl_valid  <= 1'b1;
                r_cpl_cid    <= cqe_data[111:96];
                r_cpl_status <= cqe_data[127:113];
            end else if (cpl_ready) begin
                r_cpl_valid <= 1'b0;
            end
        end
    end

    assign cpl_valid  = r_cpl_valid;
    assign cpl_cid    = r_cpl_cid;
    assign cpl_status = r_cpl_status;
    assign err_phase  = r_err_phase;

    // Doorbell sequencer; new events re-arm the pend bit so writes coalesce
    assign w_db_start = (r_state == c_idle) & (r_cq_pend | r_sq_pend);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_db_start) w_state_nxt = c_addr;
            c_addr:  if ((~r_awvalid | db_awready) && (~r_wvalid | db_wready)) w_state_nxt = c_resp;
            c_resp:  if (db_bvalid) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sq_pend   <= 1'b0;
            r_cq_pend   <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_err_bresp <= 1'b0;
        end else begin
            r_err_bresp <= (r_state == c_resp) & db_bvalid & (db_bresp != 2'b00);
            if (w_sqe_hs) begin
                r_sq_pend <= 1'b1;
            end else if (w_db_start && !r_cq_pend) begin
                r_sq_pend <= 1'b0;
            end
            if (w_cqe_acc && w_ph_ok) begin
                r_cq_pend <= 1'b1;
            end else if (w_db_start) begin
                r_cq_pend <= 1'b0;
            end
            if (w_db_start) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= r_cq_pend ? c_cq_db : c_sq_db;
                r_wdata   <= r_cq_pend ? 32'(r_cq_head) : 32'(r_sq_tail);
            end else if (r_state == c_addr) begin
                if (db_awready) r_awvalid <= 1'b0;
                if (db_wready)  r_wvalid  <= 1'b0;
            end
        end
    end

    assign db_awaddr  = r_awaddr;
    assign db_awvalid = r_awvalid;
    assign db_wdata   = r_wdata;
    assign db_wvalid  = r_wvalid;
    assign db_bready  = 1'b1;
    assign err_bresp  = r_err_bresp;

endmodule
`default_nettype wire

// File: tb/tb_nvme_queue_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_nvme_queue_engine
// Description : Directed self-checking bench for nvme_queue_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nvme_queue_engine;

    logic         clk, rst;
    logic         cmd_valid, cmd_ready, cmd_write;
    logic [63:0]  cmd_slba;
    logic [7:0]   cmd_nlb;
    logic [3:0]   cmd_cid;
    logic         sqe_valid, sqe_ready;
    logic [31:0]  sqe_addr;
    logic [511:0] sqe_data;
    logic [31:0]  db_awaddr, db_wdata;
    logic         db_awvalid, db_awready, db_wvalid, db_wready;
    logic         db_bvalid, db_bready;
    logic [1:0]   db_bresp;
    logic         cqe_valid, cqe_ready;
    logic [127:0] cqe_data;
    logic         cpl_valid, cpl_ready;
    logic [15:0]  cpl_cid;
    logic [14:0]  cpl_status;
    logic         err_phase, err_bresp;

    nvme_queue_engine dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_slba(cmd_slba), .cmd_nlb(cmd_nlb), .cmd_cid(cmd_cid),
        .sqe_valid(sqe_valid), .sqe_ready(sqe_ready), .sqe_addr(sqe_addr), .sqe_data(sqe_data),
        .db_awaddr(db_awaddr), .db_awvalid(db_awvalid), .db_awready(db_awready),
        .db_wdata(db_wdata), .db_wvalid(db_wvalid), .db_wready(db_wready),
        .db_bvalid(db_bvalid), .db_bready(db_bready), .db_bresp(db_bresp),
        .cqe_valid(cqe_valid), .cqe_ready(cqe_ready), .cqe_data(cqe_data),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_cid(cpl_cid), .cpl_status(cpl_status),
        .err_phase(err_phase), .err_bresp(err_bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [511:0] sqe_q[$];
    logic [31:0]  sqe_addr_q[$];
    logic [31:0]  aw_q[$];
    logic [31:0]  w_q[$];
    logic [15:0]  cpl_cid_q[$];
    logic [14:0]  cpl_st_q[$];
    int           aw_seen, w_seen, b_sent;
    int           err_ph_cnt, err_br_cnt;
    logic         aw_hold;
    logic [1:0]   bresp_knob;

    always @(posedge clk) begin
        if (!rst) begin
            if (sqe_valid && sqe_ready) begin
                sqe_q.push_back(sqe_data);
                sqe_addr_q.push_back(sqe_addr);
            end
            if (db_awvalid && db_awready) begin
                aw_q.push_back(db_awaddr);
                aw_seen++;
            end
            if (db_wvalid && db_wready) begin
                w_q.push_back(db_wdata);
                w_seen++;
            end
            if (cpl_valid && cpl_ready) begin
                cpl_cid_q.push_back(cpl_cid);
                cpl_st_q.push_back(cpl_status);
            end
            if (err_phase) err_ph_cnt++;
            if (err_bresp) err_br_cnt++;
        end
    end

    // AXI-Lite doorbell slave: a B beat follows each completed AW+W pair
    initial begin
        db_awready = 1'b0;
        db_wready  = 1'b0;
        db_bvalid  = 1'b0;
        db_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            db_awready = !aw_hold;
            db_wready  = 1'b1;
            if (db_bvalid) begin
                db_bvalid = 1'b0;
            end else if (b_sent < aw_seen && b_sent < w_seen) begin
                db_bvalid = 1'b1;
                db_bresp  = bresp_knob;
                b_sent++;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sqe_q.delete(); sqe_addr_q.delete(); aw_q.delete(); w_q.delete();
        cpl_cid_q.delete(); cpl_st_q.delete();
        aw_seen = 0; w_seen = 0; b_sent = 0; err_ph_cnt = 0; err_br_cnt = 0;
    endtask

    task automatic send_cmd(input logic wr, input logic [63:0] slba, input logic [7:0] nlb,
                            output logic [3:0] cid, output bit ok);
        ok = 0;
        cid = '0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_slba = slba; cmd_nlb = nlb;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (cmd_ready) begin
                cid = cmd_cid;
                ok = 1;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic push_cqe(input logic [15:0] sqhd, input logic [15:0] cid,
                            input logic [14:0] st, input logic ph, output bit ok);
        ok = 0;
        cqe_valid = 1'b1;
        cqe_data  = {st, ph, cid, 16'h0000, sqhd, 64'h0};
        for (int t = 0; t < 50 && !ok; t++) begin
            if (cqe_ready) ok = 1;
            @(negedge clk);
        end
        cqe_valid = 1'b0;
    endtask

    initial begin
        logic [3:0]   cid;
        bit           ok;
        int           n_ok;
        logic [511:0] s;

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_slba = '0; cmd_nlb = '0;
        sqe_ready = 1'b1; cqe_valid = 1'b0; cqe_data = '0; cpl_ready = 1'b1;
        aw_hold = 1'b0; bresp_knob = 2'b00;
        aw_seen = 0; w_seen = 0; b_sent = 0;
        @(negedge clk);
        do_reset();

        // reset state
        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_cmd_cid", cmd_cid, 0);
        check_val("rst_sqe_valid", sqe_valid, 0);
        check_val("rst_awvalid", db_awvalid, 0);
        check_val("rst_bready", db_bready, 1);
        check_val("rst_cpl_valid", cpl_valid, 0);

        // single WRITE, then READ spanning two pages
        send_cmd(1'b1, 64'h10, 8'd0, cid, ok);
        check_val("wr_ok", ok, 1);
        check_val("wr_cid", cid, 0);
        repeat (20) @(negedge clk);
        check_val("wr_nsqe", sqe_q.size(), 1);
        if (sqe_q.size() >= 1) begin
            s = sqe_q[0];
            check_val("wr_addr", sqe_addr_q[0], 32'h20000);
            check_val("wr_dw0", s[31:0], 32'h0000_0001);
            check_val("wr_dw1", s[63:32], 32'h1);
            check_val("wr_prp1", s[255:192], 64'h0);
            check_val("wr_prp2", s[319:256], 64'h0);
            check_val("wr_slba", s[383:320], 64'h10);
            check_val("wr_cdw12", s[415:384], 32'h0);
        end
        check_val("wr_ndb", aw_q.size(), 1);
        if (aw_q.size() >= 1 && w_q.size() >= 1) begin
            check_val("wr_db_addr", aw_q[0], 32'h1008);
            check_val("wr_db_data", w_q[0], 32'h1);
        end

        send_cmd(1'b0, 64'h1234_5678_9ABC, 8'd15, cid, ok);
        check_val("rd_cid", cid, 1);
        repeat (20) @(negedge clk);
        check_val("rd_nsqe", sqe_q.size(), 2);
        if (sqe_q.size() >= 2) begin
            s = sqe_q[1];
            check_val("rd_addr", sqe_addr_q[1], 32'h20040);
            check_val("rd_dw0", s[31:0], 32'h0001_0002);
            check_val("rd_prp1", s[255:192], 64'h1000);
            check_val("rd_prp2", s[319:256], 64'h2000);
            check_val("rd_slba", s[383:320], 64'h1234_5678_9ABC);
            check_val("rd_cdw12", s[415:384], 32'h0F);
        end
        if (w_q.size() >= 2) check_val("rd_db_data", w_q[w_q.size()-1], 32'h2);

        // fill the ring: 15 accepted, then full until a CQE moves the head
        do_reset();
        n_ok = 0;
        for (int i = 0; i < 15; i++) begin
            send_cmd(1'b1, 64'(i), 8'd0, cid, ok);
            if (ok) n_ok++;
        end
        repeat (30) @(negedge clk);
        check_val("full_accepted", n_ok, 15);
        check_val("full_ready_low", cmd_ready, 0);
        if (aw_q.size() >= 1) begin
            check_val("full_db_addr", aw_q[aw_q.size()-1], 32'h1008);
            check_val("full_db_data", w_q[w_q.size()-1], 32'd15);
        end
        push_cqe(16'd1, 16'h0003, 15'h0, 1'b1, ok);
        repeat (30) @(negedge clk);
        check_val("full_ready_back", cmd_ready, 1);
        check_val("full_cpl_cnt", cpl_cid_q.size(), 1);
        if (cpl_cid_q.size() >= 1) check_val("full_cpl_cid", cpl_cid_q[0], 16'h0003);
        if (aw_q.size() >= 1) begin
            check_val("full_cqdb_addr", aw_q[aw_q.size()-1], 32'h100C);
            check_val("full_cqdb_data", w_q[w_q.size()-1], 32'd1);
        end

        // phase wrap: 16 good, 17th stale, then phase 0 accepted
        do_reset();
        for (int i = 0; i < 16; i++) push_cqe(16'd0, 16'(i), 15'h0, 1'b1, ok);
        repeat (5) @(negedge clk);
        check_val("wrap_cpl_cnt", cpl_cid_q.size(), 16);
        if (cpl_cid_q.size() >= 16) check_val("wrap_cpl15", cpl_cid_q[15], 16'd15);
        check_val("wrap_no_err", err_ph_cnt, 0);
        push_cqe(16'd0, 16'h0099, 15'h0, 1'b1, ok);
        repeat (5) @(negedge clk);
        check_val("stale_consumed", ok, 1);
        check_val("stale_err", err_ph_cnt, 1);
        check_val("stale_no_cpl", cpl_cid_q.size(), 16);
        push_cqe(16'd0, 16'h0077, 15'h0, 1'b0, ok);
        repeat (30) @(negedge clk);
        check_val("ph0_cpl_cnt", cpl_cid_q.size(), 17);
        check_val("ph0_err", err_ph_cnt, 1);
        if (w_q.size() >= 1) check_val("ph0_cqdb_data", w_q[w_q.size()-1], 32'd1);

        // coalescing: three SQEs while AW is held
        do_reset();
        aw_hold = 1'b1;
        for (int i = 0; i < 3; i++) send_cmd(1'b0, 64'h100, 8'd0, cid, ok);
        repeat (3) @(negedge clk);
        check_val("hold_awvalid", db_awvalid, 1);
        aw_hold = 1'b0;
        repeat (30) @(negedge clk);
        check_val("coal_ndb", aw_q.size(), 2);
        if (aw_q.size() >= 2 && w_q.size() >= 2) begin
            check_val("coal_db0", w_q[0], 32'd1);
            check_val("coal_db1", w_q[1], 32'd3);
            check_val("coal_addr1", aw_q[1], 32'h1008);
        end

        // CQE and SQE complete in the same cycle: CQ doorbell goes first
        do_reset();
        sqe_ready = 1'b0;
        send_cmd(1'b1, 64'h5, 8'd0, cid, ok);
        repeat (3) @(negedge clk);
        check_val("sqe_hold", sqe_valid, 1);
        sqe_ready = 1'b1;
        cqe_valid = 1'b1;
        cqe_data  = {15'h0, 1'b1, 16'h0007, 16'h0, 16'h0, 64'h0};
        @(negedge clk);
        cqe_valid = 1'b0;
        repeat (30) @(negedge clk);
        check_val("prio_ndb", aw_q.size(), 2);
        if (aw_q.size() >= 2 && w_q.size() >= 2) begin
            check_val("prio_addr0", aw_q[0], 32'h100C);
            check_val("prio_data0", w_q[0], 32'd1);
            check_val("prio_addr1", aw_q[1], 32'h1008);
            check_val("prio_data1", w_q[1], 32'd1);
        end

        // completion backpressure and bad doorbell response
        do_reset();
        cpl_ready  = 1'b0;
        bresp_knob = 2'd2;
        push_cqe(16'd0, 16'h00A5, 15'h0011, 1'b1, ok);
        cqe_valid = 1'b1;
        cqe_data  = {15'h0, 1'b1, 16'h005A, 16'h0, 16'h0, 64'h0};
        check_val("bp_rdy0", cqe_ready, 0);
        repeat (3) @(negedge clk);
        check_val("bp_rdy1", cqe_ready, 0);
        check_val("bp_cpl_cid", cpl_cid, 16'h00A5);
        check_val("bp_cpl_st", cpl_status, 15'h0011);
        cpl_ready = 1'b1;
        @(negedge clk);
        cqe_valid = 1'b0;
        repeat (30) @(negedge clk);
        check_val("bp_cpl_cnt", cpl_cid_q.size(), 2);
        if (cpl_cid_q.size() >= 2) begin
            check_val("bp_cpl0", cpl_cid_q[0], 16'h00A5);
            check_val("bp_cpl1", cpl_cid_q[1], 16'h005A);
        end
        check_val("bresp_err_cnt", err_br_cnt, 2);
        if (w_q.size() >= 1) check_val("bp_cqdb_data", w_q[w_q.size()-1], 32'd2);
        bresp_knob = 2'd0;

        // reset abandons a pending SQE
        do_reset();
        sqe_ready = 1'b0;
        send_cmd(1'b1, 64'h9, 8'd0, cid, ok);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_sqe", sqe_valid, 0);
        check_val("midrst_cid", cmd_cid, 0);
        rst = 1'b0;
        sqe_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
